// File: rtl/dm_bytelane.sv
// dm_bytelane: MEM-stage data memory with byte/halfword load-store,
// sign/zero extension, alignment checking and a counter-driven clear
// sequence (after reset or on soft clear) flagged on oBusy.
// Optional store trace: define DM_TRACE_EN to print every committed store.
module dm_bytelane #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CLR_INIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W+1:0] iAddr,
  input  logic [31:0]       iData,
  input  logic [31:0]       iPC8,
  input  logic [2:0]        iMode,
  input  logic              iDM_WE,
  input  logic              iClr,
  output logic [31:0]       out,
  output logic              oBusy,
  output logic              oAlignErr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] M_WORD = 3'b000;
  localparam logic [2:0] M_HS   = 3'b001;
  localparam logic [2:0] M_HU   = 3'b010;
  localparam logic [2:0] M_BS   = 3'b011;
  localparam logic [2:0] M_BU   = 3'b100;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_d;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         merged_word;
  logic                align_err;
  logic                store_we;

  assign word_idx = iAddr[ADDR_W+1:2];
  assign lane     = iAddr[1:0];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
  assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // busy is a direct decode of the state flop
  assign oBusy = (state == CLEAR);

  // State and clear counter; async reset restarts the clear from word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= (CLR_INIT != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  // Next state: CLEAR walks every word once, soft clear only honoured in IDLE
  always_comb begin
    state_d   = state;
    clr_cnt_d = '0;
    case (state)
      CLEAR: begin
        clr_cnt_d = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      IDLE: begin
        if (iClr) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: alignment check, store merge and extended load data
  always_comb begin
    align_err   = 1'b0;
    merged_word = rd_word;
    out         = '0;
    case (iMode)
      M_WORD:      align_err = (lane != 2'b00);
      M_HS, M_HU:  align_err = lane[0];
      M_BS, M_BU:  align_err = 1'b0;
      default:     align_err = 1'b1;
    endcase

    case (iMode)
      M_WORD:     merged_word = iData;
      M_HS, M_HU: begin
        if (lane[1]) merged_word[31:16] = iData[15:0];
        else         merged_word[15:0]  = iData[15:0];
      end
      M_BS, M_BU: merged_word[{lane, 3'b000} +: 8] = iData[7:0];
      default:    merged_word = rd_word;
    endcase

    if (!oBusy && !align_err) begin
      case (iMode)
        M_WORD:  out = rd_word;
        M_HS:    out = {{16{rd_half[15]}}, rd_half};
        M_HU:    out = {16'h0000, rd_half};
        M_BS:    out = {{24{rd_byte[7]}}, rd_byte};
        M_BU:    out = {24'h000000, rd_byte};
        default: out = '0;
      endcase
    end

    store_we = (state == IDLE) && iDM_WE && !iClr && !align_err;
  end

  assign oAlignErr = align_err;

  // Memory array: clear writes take priority, stores are read-modify-write
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (store_we) begin
      mem[word_idx] <= merged_word;
    end
  end

`ifdef DM_TRACE_EN
  // Trace of committed stores with the full merged word
  always_ff @(posedge clk) begin
    if (reset && store_we) begin
      $display("%d@%h: *%h <= %h", $time, iPC8 - 32'd8,
               32'({iAddr[ADDR_W+1:2], 2'b00}), merged_word);
    end
  end
`else
  logic unused_pc8;
  assign unused_pc8 = ^iPC8;
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed stimulus for dm_bytelane (ADDR_W=4, CLR_INIT=1)
// with a queue-based scoreboard checked by an independent monitor.
module tb_dm_bytelane;

  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic [ADDR_W+1:0] iAddr;
  logic [31:0]       iData;
  logic [31:0]       iPC8;
  logic [2:0]        iMode;
  logic              iDM_WE;
  logic              iClr;
  logic [31:0]       out;
  logic              oBusy;
  logic              oAlignErr;

  dm_bytelane #(.ADDR_W(ADDR_W), .CLR_INIT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .iAddr     (iAddr),
    .iData     (iData),
    .iPC8      (iPC8),
    .iMode     (iMode),
    .iDM_WE    (iDM_WE),
    .iClr      (iClr),
    .out       (out),
    .oBusy     (oBusy),
    .oAlignErr (oAlignErr)
  );

  typedef struct {
    logic [31:0] eout;
    logic        ebusy;
    logic        eerr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_en;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation whenever the stimulus marks a sample cycle
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: sample with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out !== e.eout || oBusy !== e.ebusy || oAlignErr !== e.eerr) begin
          failures++;
          $display("FAIL %s: got out=%h busy=%b err=%b, expected out=%h busy=%b err=%b",
                   e.name, out, oBusy, oAlignErr, e.eout, e.ebusy, e.eerr);
        end
      end
    end
  end

  // One cycle: drive inputs, optionally queue the expected response
  task automatic cyc(input logic [5:0] a, input logic [31:0] d, input logic [2:0] m,
                     input logic we, input logic clr, input logic chk,
                     input logic [31:0] eo, input logic eb, input logic ee,
                     input string nm);
    iAddr  = a;
    iData  = d;
    iMode  = m;
    iDM_WE = we;
    iClr   = clr;
    iPC8   = 32'h0000_1000 + 32'(a);
    chk_en = chk;
    if (chk) exp_q.push_back('{eo, eb, ee, nm});
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [5:0] a, input logic [2:0] m, input logic [31:0] eo,
                    input logic ee, input string nm);
    cyc(a, 32'h0, m, 1'b0, 1'b0, 1'b1, eo, 1'b0, ee, nm);
  endtask

  task automatic busy_cycles(input int n, input string nm);
    for (int i = 0; i < n; i++)
      cyc(6'h00, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, nm);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    iAddr    = '0;
    iData    = '0;
    iPC8     = '0;
    iMode    = '0;
    iDM_WE   = 1'b0;
    iClr     = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: busy, out forced to 0
    busy_cycles(2, "reset_busy");
    reset = 1'b1;

    // Clear after release: exactly 16 busy cycles; stores and iClr ignored
    for (int i = 0; i < 16; i++) begin
      if (i == 10)
        cyc(6'h08, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, "clear_store_ignored");
      else
        cyc(6'(4 * (i % 16)), 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "init_clear");
    end
    ld(6'h08, 3'b000, 32'h0000_0000, 1'b0, "post_clear_lw8");
    ld(6'h3C, 3'b000, 32'h0000_0000, 1'b0, "post_clear_lw3c");

    // Word store then byte store into lane 1
    cyc(6'h08, 32'h1122_3344, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "sw8_old");
    cyc(6'h09, 32'hFFFF_FFAB, 3'b011, 1'b1, 1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b0, "sb9_sees_sw");
    ld(6'h08, 3'b000, 32'h1122_AB44, 1'b0, "lw8_merged");
    ld(6'h09, 3'b011, 32'hFFFF_FFAB, 1'b0, "lb9");
    ld(6'h09, 3'b100, 32'h0000_00AB, 1'b0, "lbu9");
    ld(6'h0A, 3'b001, 32'h0000_1122, 1'b0, "lh_a");
    ld(6'h0B, 3'b011, 32'h0000_0011, 1'b0, "lb_b");

    // Halfword store into upper half of word 1
    cyc(6'h06, 32'hFFFF_8001, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "");
    ld(6'h06, 3'b001, 32'hFFFF_8001, 1'b0, "lh6");
    ld(6'h06, 3'b010, 32'h0000_8001, 1'b0, "lhu6");
    ld(6'h04, 3'b000, 32'h8001_0000, 1'b0, "lw4");
    ld(6'h07, 3'b011, 32'hFFFF_FF80, 1'b0, "lb7");

    // Misaligned and reserved-mode accesses: suppressed, out 0
    cyc(6'h02, 32'h1234_5678, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, "sw_misaligned");
    cyc(6'h05, 32'h0000_5555, 3'b001, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, "sh_misaligned");
    cyc(6'h08, 32'hCAFE_F00D, 3'b110, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, "mode110");
    cyc(6'h04, 32'hCAFE_F00D, 3'b101, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, "mode101");
    ld(6'h00, 3'b000, 32'h0000_0000, 1'b0, "lw0_unchanged");
    ld(6'h04, 3'b000, 32'h8001_0000, 1'b0, "lw4_unchanged");
    ld(6'h08, 3'b000, 32'h1122_AB44, 1'b0, "lw8_unchanged");

    // Soft clear together with a store: clear wins
    cyc(6'h00, 32'hDEAD_BEEF, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, "clr_with_sw");
    busy_cycles(7, "soft_clear");
    // Reset at clear cycle 7
    reset = 1'b0;
    busy_cycles(2, "reset_mid_clear");
    reset = 1'b1;
    busy_cycles(16, "restart_clear");
    ld(6'h00, 3'b000, 32'h0000_0000, 1'b0, "lw0_store_dropped");
    ld(6'h08, 3'b000, 32'h0000_0000, 1'b0, "lw8_cleared");
    ld(6'h04, 3'b000, 32'h0000_0000, 1'b0, "lw4_cleared");

    chk_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
